// File: rtl/camera_capture_sequencer.sv
// Avalon-MM master that programs the camera register slave, starts a capture,
// polls the captured flag with a bounded budget, then stops and clears it.
module camera_capture_sequencer #(
  parameter int POLL_GAP      = 16,
  parameter int TIMEOUT_POLLS = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        go,
  input  logic [15:0] cfg_width,
  input  logic [15:0] cfg_height,
  input  logic [15:0] cfg_exposure,
  input  logic [23:0] cfg_imgsize,
  input  logic [31:0] cfg_buff,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [15:0] frames_count,
  output logic [4:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_POLL_RD,
    S_POLL_WAIT,
    S_GAP,
    S_STOP,
    S_CLEAR,
    S_FINISH
  } state_t;

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_POLLS);
  localparam logic [15:0] GAP_LAST    = 16'(POLL_GAP - 1);
  localparam logic [2:0]  LAST_STEP   = 3'd6;
  localparam logic [4:0]  ADDR_CTRL   = 5'h00;
  localparam logic [4:0]  ADDR_FLAG   = 5'h03;

  state_t      state_reg, state_next;
  logic [2:0]  step_reg, step_next;
  logic [15:0] poll_cnt_reg, poll_cnt_next;
  logic [15:0] gap_cnt_reg, gap_cnt_next;
  logic        timeout_reg, timeout_next;
  logic [15:0] frames_count_reg, frames_count_next;
  logic [15:0] width_reg, width_next;
  logic [15:0] height_reg, height_next;
  logic [15:0] exposure_reg, exposure_next;
  logic [23:0] imgsize_reg, imgsize_next;
  logic [31:0] buff_reg, buff_next;

  logic [4:0]  step_addr;
  logic [31:0] step_data;
  logic        unused_readdata;

  // Only the captured flag bit of the status word matters here.
  assign unused_readdata = ^avm_readdata[31:1];
  assign frames_count    = frames_count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= S_IDLE;
      step_reg         <= 3'd0;
      poll_cnt_reg     <= 16'd0;
      gap_cnt_reg      <= 16'd0;
      timeout_reg      <= 1'b0;
      frames_count_reg <= 16'd0;
      width_reg        <= 16'd0;
      height_reg       <= 16'd0;
      exposure_reg     <= 16'd0;
      imgsize_reg      <= 24'd0;
      buff_reg         <= 32'd0;
    end else begin
      state_reg        <= state_next;
      step_reg         <= step_next;
      poll_cnt_reg     <= poll_cnt_next;
      gap_cnt_reg      <= gap_cnt_next;
      timeout_reg      <= timeout_next;
      frames_count_reg <= frames_count_next;
      width_reg        <= width_next;
      height_reg       <= height_next;
      exposure_reg     <= exposure_next;
      imgsize_reg      <= imgsize_next;
      buff_reg         <= buff_next;
    end
  end

  // Configuration write table, indexed by the WRITE step.
  always_comb begin
    step_addr = 5'h00;
    step_data = 32'h0000_0000;
    case (step_reg)
      3'd0: begin step_addr = 5'h09;     step_data = {16'h0000, width_reg};    end
      3'd1: begin step_addr = 5'h0A;     step_data = {16'h0000, height_reg};   end
      3'd2: begin step_addr = 5'h11;     step_data = {16'h0000, exposure_reg}; end
      3'd3: begin step_addr = 5'h01;     step_data = {8'h00, imgsize_reg};     end
      3'd4: begin step_addr = 5'h02;     step_data = buff_reg;                 end
      3'd5: begin step_addr = ADDR_FLAG; step_data = 32'h0000_0000;            end
      3'd6: begin step_addr = ADDR_CTRL; step_data = 32'h0000_0001;            end
      default: begin step_addr = 5'h00;  step_data = 32'h0000_0000;            end
    endcase
  end

  always_comb begin
    state_next        = state_reg;
    step_next         = step_reg;
    poll_cnt_next     = poll_cnt_reg;
    gap_cnt_next      = gap_cnt_reg;
    timeout_next      = timeout_reg;
    frames_count_next = frames_count_reg;
    width_next        = width_reg;
    height_next       = height_reg;
    exposure_next     = exposure_reg;
    imgsize_next      = imgsize_reg;
    buff_next         = buff_reg;
    busy              = (state_reg != S_IDLE);
    done              = 1'b0;
    timeout_err       = 1'b0;
    avm_read          = 1'b0;
    avm_write         = 1'b0;
    avm_address       = 5'h00;
    avm_writedata     = 32'h0000_0000;

    case (state_reg)
      S_IDLE: begin
        if (go) begin
          width_next    = cfg_width;
          height_next   = cfg_height;
          exposure_next = cfg_exposure;
          imgsize_next  = cfg_imgsize;
          buff_next     = cfg_buff;
          step_next     = 3'd0;
          poll_cnt_next = 16'd0;
          timeout_next  = 1'b0;
          state_next    = S_WRITE;
        end
      end

      S_WRITE: begin
        avm_write     = 1'b1;
        avm_address   = step_addr;
        avm_writedata = step_data;
        if (!avm_waitrequest) begin
          if (step_reg == LAST_STEP) begin
            state_next = S_POLL_RD;
          end else begin
            step_next = step_reg + 3'd1;
          end
        end
      end

      S_POLL_RD: begin
        avm_read    = 1'b1;
        avm_address = ADDR_FLAG;
        if (!avm_waitrequest) begin
          poll_cnt_next = poll_cnt_reg + 16'd1;
          state_next    = S_POLL_WAIT;
        end
      end

      // Read data is valid exactly one cycle after the read is accepted.
      S_POLL_WAIT: begin
        if (avm_readdata[0]) begin
          state_next = S_STOP;
        end else if (poll_cnt_reg >= TIMEOUT_LIM) begin
          timeout_next = 1'b1;
          state_next   = S_STOP;
        end else begin
          gap_cnt_next = 16'd0;
          state_next   = S_GAP;
        end
      end

      S_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = S_POLL_RD;
        end else begin
          gap_cnt_next = gap_cnt_reg + 16'd1;
        end
      end

      S_STOP: begin
        avm_write     = 1'b1;
        avm_address   = ADDR_CTRL;
        avm_writedata = 32'h0000_0000;
        if (!avm_waitrequest) begin
          state_next = S_CLEAR;
        end
      end

      S_CLEAR: begin
        avm_write     = 1'b1;
        avm_address   = ADDR_FLAG;
        avm_writedata = 32'h0000_0000;
        if (!avm_waitrequest) begin
          state_next = S_FINISH;
        end
      end

      S_FINISH: begin
        if (timeout_reg) begin
          timeout_err = 1'b1;
        end else begin
          done              = 1'b1;
          frames_count_next = frames_count_reg + 16'd1;
        end
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_camera_capture_sequencer.sv
// Randomised bench for camera_capture_sequencer: a driver queues the expected bus
// commands and outcomes, a negedge monitor pops and compares what the DUT presents.
module tb_camera_capture_sequencer;

  localparam int G  = 4;
  localparam int TO = 5;

  logic        clk;
  logic        reset_n;
  logic        go;
  logic [15:0] cfg_width, cfg_height, cfg_exposure;
  logic [23:0] cfg_imgsize;
  logic [31:0] cfg_buff;
  logic        busy, done, timeout_err;
  logic [15:0] frames_count;
  logic [4:0]  avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata, avm_readdata;
  logic        avm_waitrequest;

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
    int          base;
  } cmd_t;

  typedef struct {
    bit          to;
    int          cyc;
    int          base;
    logic [15:0] fc;
  } out_t;

  cmd_t        exp_q[$];
  out_t        out_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          stall_total = 0;
  int          outcomes = 0;
  bit          stall_en = 0;
  int          flag_after = 0;
  int          slave_idx = 0;
  bit          rd_acc = 0;
  logic [15:0] model_frames = 16'd0;

  camera_capture_sequencer #(.POLL_GAP(G), .TIMEOUT_POLLS(TO)) dut (
    .clk(clk), .reset_n(reset_n), .go(go),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_exposure(cfg_exposure),
    .cfg_imgsize(cfg_imgsize), .cfg_buff(cfg_buff),
    .busy(busy), .done(done), .timeout_err(timeout_err), .frames_count(frames_count),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input bit ok, input string name,
                                input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void push_cmd(input bit wr, input logic [4:0] addr,
                                   input logic [31:0] data, input int c, input int b);
    cmd_t e;
    e.wr = wr; e.addr = addr; e.data = data; e.cyc = c; e.base = b;
    exp_q.push_back(e);
  endfunction

  // Slave: random stalls; status read returns the flag once enough polls have failed.
  initial begin
    avm_readdata    = 32'h0;
    avm_waitrequest = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rd_acc) begin
        avm_readdata = {31'($urandom), (slave_idx >= flag_after)};
        slave_idx++;
      end else begin
        avm_readdata = $urandom;
      end
      avm_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit          prev_stall;
    bit          prev_rd, prev_wr;
    logic [4:0]  prev_addr;
    logic [31:0] prev_data;
    bit          chk_after;
    logic [15:0] chk_fc;
    cmd_t        e;
    out_t        o;
    prev_stall = 0; chk_after = 0; chk_fc = 16'd0;
    prev_rd = 0; prev_wr = 0; prev_addr = 5'h0; prev_data = 32'h0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        check({avm_read, avm_write, done, timeout_err, busy} == 5'b0, "reset_quiet",
              64'({avm_read, avm_write, done, timeout_err, busy}), 64'h0);
        prev_stall = 0; rd_acc = 0; chk_after = 0;
      end else begin
        if (chk_after) begin
          check(frames_count == chk_fc, "frames_count", 64'(frames_count), 64'(chk_fc));
          check(busy == 1'b0, "busy_after_pulse", 64'(busy), 64'h0);
          chk_after = 0;
        end
        if (avm_read || avm_write)
          check(!(avm_read && avm_write), "rd_wr_exclusive",
                64'({avm_read, avm_write}), 64'h0);
        if (prev_stall)
          check({prev_rd, prev_wr, prev_addr, prev_data} ==
                {avm_read, avm_write, avm_address, avm_writedata}, "stall_stable",
                64'({avm_read, avm_write, avm_address, avm_writedata}),
                64'({prev_rd, prev_wr, prev_addr, prev_data}));
        if ((avm_read || avm_write) && !avm_waitrequest) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_cmd", 64'({avm_write, avm_address}), 64'h0);
          end else begin
            e = exp_q.pop_front();
            check({avm_write, avm_address, (avm_write ? avm_writedata : 32'h0)} ==
                  {e.wr, e.addr, e.data}, "cmd",
                  64'({avm_write, avm_address, (avm_write ? avm_writedata : 32'h0)}),
                  64'({e.wr, e.addr, e.data}));
            check(cyc == e.cyc + stall_total - e.base, "cmd_cycle",
                  64'(cyc), 64'(e.cyc + stall_total - e.base));
          end
        end
        if ((avm_read || avm_write) && avm_waitrequest) stall_total++;
        prev_stall = (avm_read || avm_write) && avm_waitrequest;
        prev_rd = avm_read; prev_wr = avm_write;
        prev_addr = avm_address; prev_data = avm_writedata;
        rd_acc = avm_read && !avm_waitrequest;
        if (done || timeout_err) begin
          if (out_q.size() == 0) begin
            check(1'b0, "unexpected_pulse", 64'({done, timeout_err}), 64'h0);
          end else begin
            o = out_q.pop_front();
            check({timeout_err, done} == {o.to, !o.to}, "outcome",
                  64'({timeout_err, done}), 64'({o.to, !o.to}));
            check(cyc == o.cyc + stall_total - o.base, "outcome_cycle",
                  64'(cyc), 64'(o.cyc + stall_total - o.base));
            check(exp_q.size() == 0, "cmds_pending", 64'(exp_q.size()), 64'h0);
            check(busy == 1'b1, "busy_at_pulse", 64'(busy), 64'h1);
            chk_after = 1; chk_fc = o.fc;
          end
          outcomes++;
        end
      end
    end
  end

  function automatic void set_random_cfg();
    cfg_width    = 16'($urandom);
    cfg_height   = 16'($urandom);
    cfg_exposure = 16'($urandom);
    cfg_imgsize  = 24'($urandom);
    cfg_buff     = $urandom;
  endfunction

  // One start request; expected timing is derived from the zero-wait schedule:
  // writes on 1..7, read i on 8+i*(G+2), stop/clear/pulse right after the last read.
  task automatic run_seq(input logic [15:0] w, input logic [15:0] h, input logic [15:0] ex,
                         input logic [23:0] sz, input logic [31:0] bf,
                         input int fa, input bit disturb);
    int g, base, p, rl, tgt, n;
    bit to;
    @(posedge clk);
    #1;
    cfg_width = w; cfg_height = h; cfg_exposure = ex; cfg_imgsize = sz; cfg_buff = bf;
    go = 1'b1;
    g = cyc; base = stall_total; slave_idx = 0; flag_after = fa;
    push_cmd(1, 5'h09, {16'h0, w}, g + 1, base);
    push_cmd(1, 5'h0A, {16'h0, h}, g + 2, base);
    push_cmd(1, 5'h11, {16'h0, ex}, g + 3, base);
    push_cmd(1, 5'h01, {8'h0, sz}, g + 4, base);
    push_cmd(1, 5'h02, bf, g + 5, base);
    push_cmd(1, 5'h03, 32'h0, g + 6, base);
    push_cmd(1, 5'h00, 32'h1, g + 7, base);
    to = (fa >= TO);
    p  = to ? TO : fa + 1;
    for (int i = 0; i < p; i++) push_cmd(0, 5'h03, 32'h0, g + 8 + i * (G + 2), base);
    rl = g + 8 + (p - 1) * (G + 2);
    push_cmd(1, 5'h00, 32'h0, rl + 2, base);
    push_cmd(1, 5'h03, 32'h0, rl + 3, base);
    if (!to) model_frames = model_frames + 16'd1;
    out_q.push_back('{to, rl + 4, base, model_frames});
    tgt = outcomes + 1;
    @(posedge clk);
    #1;
    go = 1'b0;
    if (disturb) begin
      repeat (2) @(posedge clk);
      #1;
      go = 1'b1;
      set_random_cfg();
      @(posedge clk);
      #1;
      go = 1'b0;
      set_random_cfg();
    end
    n = 0;
    while (outcomes < tgt && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check(outcomes >= tgt, "seq_complete", 64'(outcomes), 64'(tgt));
    if (outcomes < tgt) begin
      exp_q.delete();
      out_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic reset_mid_poll();
    int g, base;
    @(posedge clk);
    #1;
    set_random_cfg();
    go = 1'b1;
    g = cyc; base = stall_total; slave_idx = 0; flag_after = 1000;
    push_cmd(1, 5'h09, {16'h0, cfg_width}, g + 1, base);
    push_cmd(1, 5'h0A, {16'h0, cfg_height}, g + 2, base);
    push_cmd(1, 5'h11, {16'h0, cfg_exposure}, g + 3, base);
    push_cmd(1, 5'h01, {8'h0, cfg_imgsize}, g + 4, base);
    push_cmd(1, 5'h02, cfg_buff, g + 5, base);
    push_cmd(1, 5'h03, 32'h0, g + 6, base);
    push_cmd(1, 5'h00, 32'h1, g + 7, base);
    push_cmd(0, 5'h03, 32'h0, g + 8, base);
    @(posedge clk);
    #1;
    go = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check({busy, done, timeout_err, frames_count, avm_address, avm_read, avm_write,
           avm_writedata} == '0, "async_reset_outputs",
          64'({busy, done, timeout_err, frames_count, avm_address, avm_read, avm_write}),
          64'h0);
    check(exp_q.size() == 0, "pre_reset_cmds", 64'(exp_q.size()), 64'h0);
    exp_q.delete();
    out_q.delete();
    model_frames = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    go = 1'b0;
    cfg_width = 16'h0; cfg_height = 16'h0; cfg_exposure = 16'h0;
    cfg_imgsize = 24'h0; cfg_buff = 32'h0;
    #2;
    check({busy, done, timeout_err, frames_count, avm_address, avm_read, avm_write,
           avm_writedata} == '0, "reset_outputs",
          64'({busy, done, timeout_err, frames_count, avm_address, avm_read, avm_write}),
          64'h0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Zero-wait happy path, delayed flag, timeout.
    run_seq(16'd320, 16'd240, 16'h07C0, 24'd76800, 32'h2000_0000, 0, 0);
    run_seq(16'($urandom), 16'($urandom), 16'($urandom), 24'($urandom), $urandom, 3, 0);
    run_seq(16'($urandom), 16'($urandom), 16'($urandom), 24'($urandom), $urandom, 100, 0);

    // Random stalls, with and without mid-run go/cfg disturbance.
    stall_en = 1;
    for (int i = 0; i < 8; i++)
      run_seq(16'($urandom), 16'($urandom), 16'($urandom), 24'($urandom), $urandom,
              $urandom_range(0, 6), i[0]);
    stall_en = 0;
    run_seq(16'd640, 16'd480, 16'h0100, 24'd307200, 32'h1000_0000, 1, 1);

    // Reset during GAP, then a fresh start.
    reset_mid_poll();
    run_seq(16'd320, 16'd240, 16'h07C0, 24'd76800, 32'h2000_0000, 0, 0);

    // Frame counter wrap.
    force dut.frames_count_reg = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.frames_count_reg;
    model_frames = 16'hFFFF;
    run_seq(16'($urandom), 16'($urandom), 16'($urandom), 24'($urandom), $urandom, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/camera_capture_sequencer.md
# camera_capture_sequencer

Avalon-MM master that drives the camera controller's register slave from the other end of the bus. On a single `go` pulse it writes the capture configuration, starts a capture, polls the image-captured flag until it sets or a poll budget runs out, then stops the capture and clears the flag. It replaces software register sequencing when a hard processor is not in the loop, and sits on the same Avalon interconnect segment as the camera register slave.

## Interface
- `POLL_GAP`, 16: idle cycles between consecutive status polls (≥1).
- `TIMEOUT_POLLS`, 1024: maximum status reads before a timeout is declared (1..65535).
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `go`  in  1  start request; sampled only in IDLE.
- `cfg_width`, `cfg_height`, `cfg_exposure`  in  16 each  camera configuration values.
- `cfg_imgsize`  in  24  capture size in pixels.
- `cfg_buff`  in  32  capture buffer address.
- `busy`  out  1  high from the cycle after `go` is accepted until the done/timeout pulse.
- `done`  out  1  one-cycle pulse on a successful capture.
- `timeout_err`  out  1  one-cycle pulse on a poll-budget exhaustion.
- `frames_count`  out  16  count of successful captures; wraps from 0xFFFF to 0.
- `avm_address`  out  5  word address.
- `avm_read`, `avm_write`  out  1 each  bus commands; never high together.
- `avm_writedata`  out  32.
- `avm_readdata`  in  32  valid exactly 1 cycle after a read is accepted.
- `avm_waitrequest`  in  1  stalls the current command.

## Operation
- States: IDLE, WRITE (step index 0..6), POLL_RD, POLL_WAIT, GAP, STOP, CLEAR, FINISH.
- In IDLE with `go`=1, all `cfg_*` inputs are latched. Later changes are ignored until the next start. `go` while busy is ignored.
- WRITE sequence: 0x09←width, 0x0A←height, 0x11←exposure, 0x01←{8'b0,imgsize}, 0x02←buff, 0x03←0 (clear stale flag), 0x00←1 (start capture). Unused upper writedata bits are zero.
- POLL_RD issues a read of 0x03. POLL_WAIT samples `avm_readdata[0]` on the cycle after acceptance.
  - If the bit is 1, go to STOP.
  - If the bit is 0 and the poll count is below TIMEOUT_POLLS, go to GAP, wait POLL_GAP cycles, then return to POLL_RD.
  - If the bit is 0 and the poll count equals TIMEOUT_POLLS, go to STOP with the timeout flag set.
- STOP writes 0x00←0. CLEAR writes 0x03←0. FINISH pulses `done` (and increments `frames_count`), or pulses `timeout_err` instead when the timeout flag is set. FINISH then returns to IDLE.
- The poll counter is 16 bits, resets to 0 at each start and increments on each accepted read.
- A command is accepted on a cycle where it is asserted and `avm_waitrequest`=0. While stalled, address, writedata and command stay stable.

## Timing
- Reset value of every output is 0: `busy`, `done`, `timeout_err`, `frames_count`, `avm_*`.
- Asynchronous reset mid-operation aborts to IDLE immediately. No STOP or CLEAR writes are issued.
- With `avm_waitrequest`=0 and `go` sampled at cycle 0:
  - The seven writes occupy cycles 1–7.
  - The first read is on cycle 8, with `avm_readdata` sampled on cycle 9.
  - If the flag is set on the first poll: STOP on cycle 10, CLEAR on cycle 11, `done` on cycle 12, `busy` low on cycle 13.
- Each failed poll adds 1 sample cycle plus POLL_GAP gap cycles before the next read. Read-to-read spacing is therefore POLL_GAP+2 cycles with no stalls.
- Each waitrequest cycle delays its command and everything after it by one cycle.
- The bus is idle (`avm_read`=`avm_write`=0) in IDLE, POLL_WAIT, GAP and FINISH.
- A `frames_count` of 0xFFFF followed by a successful capture reads 0x0000 on the cycle after `done`.

## Test plan
- **Zero-wait happy path:** `go` with width=320, height=240, exposure=0x07C0, imgsize=76800, buff=0x2000_0000; slave flag set at once. Required: the seven writes above in exact order on cycles 1–7, read on cycle 8, STOP/CLEAR on cycles 10–11, `done` on cycle 12, `frames_count`=1.
- **Stalls:** random `avm_waitrequest` (50%). Required: identical accepted-command order and values, address/data stable during every stall, never both `avm_read` and `avm_write` high.
- **Delayed flag:** POLL_GAP=4; flag set after the 3rd poll. Required: exactly 4 reads spaced 6 cycles apart, then `done`.
- **Timeout:** TIMEOUT_POLLS=5; flag never set. Required: exactly 5 reads, then STOP and CLEAR writes, then a `timeout_err` pulse, no `done`, and `frames_count` unchanged.
- **Reset mid-poll:** assert `reset_n` low during GAP. Required: all outputs 0 immediately, no further bus commands, and a fresh `go` restarts from write 0x09.
- **Ignored inputs and wrap:** pulse `go` again while busy and change the `cfg_*` inputs mid-run. Required: no second sequence and latched values unchanged. Preload `frames_count` to 0xFFFF via 65535 fast captures (or force); the next `done` gives 0.
